// File: rtl/nerv_mem_arbiter.sv
// =============================================================================
// Module      : nerv_mem_arbiter
// Description : Sequences the nerv core's data access and instruction fetch
//               over one variable-latency memory port, stalling the core
//               between steps. Optional fetch buffer: NERV_ARB_IBUF_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module nerv_mem_arbiter #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clock,
    input  logic        resetn,
    output logic        stall,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam logic [15:0] c_wait_last = 16'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_CAPTURE = 2'd0,
        S_DATA    = 2'd1,
        S_FETCH   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] iaddr_q, iaddr_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] imem_data_q, imem_data_d;
    logic [31:0] dmem_rdata_q, dmem_rdata_d;
    logic        err_q, err_d;
    logic [15:0] wait_q, wait_d;

    logic        w_ack, w_tmo, w_xfer_end;
    logic [31:0] w_rdata;
    logic        w_hit_new, w_hit_cur;
    logic        w_unused;

    assign w_ack      = mem_valid_q && mem_ready;
    assign w_tmo      = mem_valid_q && !mem_ready && (wait_q == c_wait_last);
    assign w_xfer_end = w_ack || w_tmo;
    assign w_rdata    = w_ack ? mem_rdata : 32'h0;
    assign w_unused   = ^{imem_addr[1:0], dmem_addr[1:0]};

`ifdef NERV_ARB_IBUF_EN
    logic [29:0] tag_q, tag_d;
    logic        tag_vld_q, tag_vld_d;
    logic        w_wr_clear;

    // A write completing to the buffered word must invalidate it before the
    // same step decides whether its fetch can be skipped.
    assign w_wr_clear = (mem_wstrb_q != 4'h0) && (mem_addr_q[31:2] == tag_q);
    assign w_hit_new  = tag_vld_q && (imem_addr[31:2] == tag_q);
    assign w_hit_cur  = tag_vld_q && !w_wr_clear && (iaddr_q == tag_q);

    always_comb begin
        tag_d     = tag_q;
        tag_vld_d = tag_vld_q;
        if (w_xfer_end && state_q == S_DATA && w_wr_clear) begin
            tag_vld_d = 1'b0;
        end
        if (w_xfer_end && state_q == S_FETCH) begin
            tag_d     = iaddr_q;
            tag_vld_d = w_ack;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tag_q     <= 30'h0;
            tag_vld_q <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            tag_vld_q <= tag_vld_d;
        end
    end
`else
    assign w_hit_new = 1'b0;
    assign w_hit_cur = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        iaddr_d      = iaddr_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        imem_data_d  = imem_data_q;
        dmem_rdata_d = dmem_rdata_q;
        err_d        = err_q || w_tmo;
        wait_d       = wait_q;

        if (w_xfer_end) begin
            wait_d = 16'h0;
        end else if (mem_valid_q && !mem_ready) begin
            wait_d = wait_q + 16'h1;
        end

        case (state_q)
            S_CAPTURE, S_RELEASE: begin
                iaddr_d = imem_addr[31:2];
                if (dmem_valid) begin
                    state_d     = S_DATA;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = {dmem_addr[31:2], 2'b00};
                    mem_wstrb_d = dmem_wstrb;
                    mem_wdata_d = dmem_wdata;
                end else if (w_hit_new) begin
                    state_d = S_RELEASE;
                end else begin
                    state_d     = S_FETCH;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = {imem_addr[31:2], 2'b00};
                    mem_wstrb_d = 4'h0;
                    mem_wdata_d = 32'h0;
                end
            end
            S_DATA: begin
                if (w_xfer_end) begin
                    mem_valid_d = 1'b0;
                    if (mem_wstrb_q == 4'h0) begin
                        dmem_rdata_d = w_rdata;
                    end
                    if (w_hit_cur) begin
                        state_d = S_RELEASE;
                    end else begin
                        // Back-to-back fetch: the data transfer has ended, so
                        // the fetch is a fresh request in the following cycle.
                        state_d     = S_FETCH;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {iaddr_q, 2'b00};
                        mem_wstrb_d = 4'h0;
                        mem_wdata_d = 32'h0;
                    end
                end
            end
            S_FETCH: begin
                if (w_xfer_end) begin
                    mem_valid_d = 1'b0;
                    imem_data_d = w_rdata;
                    state_d     = S_RELEASE;
                end
            end
            default: begin
                state_d = S_CAPTURE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_CAPTURE;
            iaddr_q      <= 30'h0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wstrb_q  <= 4'h0;
            mem_wdata_q  <= 32'h0;
            imem_data_q  <= 32'h0;
            dmem_rdata_q <= 32'h0;
            err_q        <= 1'b0;
            wait_q       <= 16'h0;
        end else begin
            state_q      <= state_d;
            iaddr_q      <= iaddr_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            imem_data_q  <= imem_data_d;
            dmem_rdata_q <= dmem_rdata_d;
            err_q        <= err_d;
            wait_q       <= wait_d;
        end
    end

    assign stall      = (state_q != S_RELEASE);
    assign imem_data  = imem_data_q;
    assign dmem_rdata = dmem_rdata_q;
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;
    assign err        = err_q;

endmodule

`default_nettype wire
